uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised UART transmitter, the next generation of the fixed 8-bit/even-parity/9600-baud Tx. Data width, parity mode, stop-bit count and bit period are set by parameters. A small FIFO with a valid/ready handshake lets the core queue several characters and send them back-to-back with no idle gap. It sits between the core's memory-mapped UART register block and the tx pin.

Parameters:
DATA_BITS, 8, data bits per frame; legal values 5..9; sent LSB first.
PARITY_MODE, 1, parity mode: 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.
BIT_CYCLES, 5208, clk cycles per bit (50 MHz / 9600 baud); minimum 4.
FIFO_DEPTH, 4, transmit FIFO entries; must be a power of 2, minimum 2.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
tx_data  in  DATA_BITS  character to queue
tx_valid  in  1  tx_data is valid this cycle
tx_ready  out  1  FIFO can accept; equals !full
tx  out  1  serial line, idles high
tx_busy  out  1  high while the FSM is not in IDLE
tx_done  out  1  one-cycle pulse on the last clk of the final stop bit
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of queued entries
tx_state_out  out  3  debug: FSM state encoding

Behaviour:
- Reset (rst low, async):
  - FIFO is emptied; fifo_count = 0, tx_ready = 1.
  - FSM goes to IDLE; tx = 1, tx_busy = 0, tx_done = 0.
  - Bit timer and bit counter = 0.
  - Reset mid-frame aborts the frame immediately: tx returns high and no tx_done is issued.
- Push: a write occurs on a rising edge with tx_valid & tx_ready. When full, tx_valid is ignored; the data is dropped and no state changes.
- Pop: happens only on the IDLE->START or STOP->START transition. It latches the head entry into the shift register and latches the parity bit.
- Same-cycle push and pop: both are performed and fifo_count is unchanged. Push into an empty FIFO cannot pop in that same cycle.
- Pointers wrap modulo FIFO_DEPTH. fifo_count saturates at neither end, because the handshake prevents overflow and underflow.
- Parity bit: even = XOR of the data bits; odd = its inverse; none = no parity slot.
- FSM states and encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
  - IDLE: tx = 1. If fifo_count != 0, pop and go to START.
  - START: tx = 0 for BIT_CYCLES clocks, then go to DATA with bit count = 0.
  - DATA: tx = shift register bit 0 for BIT_CYCLES clocks, then shift right and increment the count. After DATA_BITS bits, go to PARITY, or to STOP if PARITY_MODE = 0.
  - PARITY: tx = latched parity bit for BIT_CYCLES clocks, then go to STOP.
  - STOP: tx = 1 for STOP_BITS*BIT_CYCLES clocks. On the last clock tx_done = 1. Then, if fifo_count != 0, pop and go directly to START (back-to-back frames); otherwise go to IDLE.
- Latency: a push into an empty FIFO while IDLE drives tx low 2 clocks after the push edge. Push at edge N, pop at edge N+1, tx = 0 from edge N+2.
- Frame length: BIT_CYCLES*(1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS) clocks, exact, with zero jitter.
- The bit timer restarts at 0 on every state entry. It never free-runs across frames.
- tx is registered and glitch-free. tx_busy and tx_done are registered.

Test Plan:
1. Reset, then a single push; BIT_CYCLES=16, DATA_BITS=8, PARITY_MODE=1, STOP_BITS=1, push 8'hA5 -> tx low 2 clocks after push. Bits 1,0,1,0,0,1,0,1, then parity 0, then stop 1; frame is 176 clocks. tx_done pulses on clock 176.
2. Odd parity with 2 stop bits; PARITY_MODE=2, STOP_BITS=2, push 8'h07 -> parity bit 0. Stop is high for 32 clocks; frame is 192 clocks.
3. No parity, 7 data bits; DATA_BITS=7, PARITY_MODE=0, push 7'h41 -> bits 1,0,0,0,0,0,1, then stop. Frame is 144 clocks with no parity slot.
4. FIFO fill and back-to-back; FIFO_DEPTH=4, push 5 words in 5 consecutive cycles while IDLE. The first word is popped at cycle 2, so all 5 are accepted and tx_ready drops. Frames are sent contiguously: START follows STOP with no idle clock, tx_done pulses 5 times, fifo_count reaches 0 and tx_busy falls.
5. Push while full; hold tx_valid with a 4-entry FIFO during a frame -> the extra word is not stored and fifo_count stays at 4. Output order matches accepted push order.
6. Reset mid-frame; assert rst during the DATA bit 3 slot -> tx = 1 immediately, fifo_count = 0, tx_state_out = 0, and no tx_done pulse. A fresh push after release sends a correct frame.

Source files
------------

// File: rtl/uart_tx_param_if.sv
// Character handshake between the UART register block and the transmitter.
// Latency: none, this is wiring only.
// Backpressure: the transmitter holds tx_ready low while its queue is full.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  // Register block side: offers characters.
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  // Transmitter side: accepts characters.
  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a small character queue ahead of the shifter.
// Latency: push into an empty queue while idle drives the start bit 2 clocks later.
// Backpressure: tx_ready = !full; when full, offered characters are dropped.

// Generic synchronous FIFO. Writes when wr_vld & wr_rdy and pops on rd_pop.
// rd_dat always shows the head entry.
// The caller only pops when count != 0.
module uart_tx_param_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_vld,
  output logic                     wr_rdy,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_pop,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             push;

  assign wr_rdy = (count_q != FULL_CNT);
  assign push   = wr_vld & wr_rdy;
  assign rd_dat = mem_q[rd_ptr_q];
  assign count  = count_q;

  // Next-state for storage, pointers (wrap by width) and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, rd_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Queue state registers; reset empties the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

module uart_tx_param #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int BIT_CYCLES  = 5208,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_param_if.slave                bus,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [2:0]                    tx_state_out
);
  localparam int STOP_CYCLES = STOP_BITS * BIT_CYCLES;
  localparam int TW          = $clog2(STOP_CYCLES);
  localparam int CW          = $clog2(DATA_BITS);

  localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_CYCLES - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_CYCLES - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 pop;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;
  logic                 have_data;

  uart_tx_param_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (bus.tx_valid),
    .wr_rdy (bus.tx_ready),
    .wr_dat (bus.tx_data),
    .rd_pop (pop),
    .rd_dat (head),
    .count  (fifo_count)
  );

  assign have_data = (fifo_count != '0);
  // Even parity is the XOR of the data bits; odd parity inverts it.
  assign head_par  = (PARITY_MODE == 2) ? ~(^head) : (^head);

  // Frame sequencer: bit timer restarts on every state entry, pops on frame start.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    pop       = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (have_data) begin
          pop     = 1'b1;
          shreg_d = head;
          par_d   = head_par;
          state_d = S_START;
        end
      end
      S_START: begin
        if (timer_q == BIT_LAST) begin
          timer_d   = '0;
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d   = '0;
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (timer_q == STOP_LAST) begin
          timer_d = '0;
          done_d  = 1'b1;
          if (have_data) begin
            // Back-to-back: next start bit follows the stop bit directly.
            pop     = 1'b1;
            shreg_d = head;
            par_d   = head_par;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Line level for the current state; registered one clock behind the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_q[0];
      S_PARITY: tx_d = par_q;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Sequencer and output registers; reset aborts any frame with the line high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_done      = done_q;
  assign tx_state_out = state_q;
endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three instances cover even/1-stop, odd/2-stop and 7-bit no-parity.
// Expected line waveforms are built from the frame format with plain arithmetic.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_tx_param;
  localparam int BC = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_param_if #(.DATA_BITS(8)) if_a ();
  uart_tx_param_if #(.DATA_BITS(8)) if_b ();
  uart_tx_param_if #(.DATA_BITS(7)) if_c ();

  logic       tx_a, busy_a, done_a;
  logic       tx_b, busy_b, done_b;
  logic       tx_c, busy_c, done_c;
  logic [2:0] cnt_a, cnt_b, cnt_c;
  logic [2:0] st_a, st_b, st_c;

  uart_tx_param #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .BIT_CYCLES(BC), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave), .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a),
    .fifo_count(cnt_a), .tx_state_out(st_a));
  uart_tx_param #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2), .BIT_CYCLES(BC), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave), .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b),
    .fifo_count(cnt_b), .tx_state_out(st_b));
  uart_tx_param #(.DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(1), .BIT_CYCLES(BC), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .rst(rst), .bus(if_c.slave), .tx(tx_c), .tx_busy(busy_c), .tx_done(done_c),
    .fifo_count(cnt_c), .tx_state_out(st_c));

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int d4[5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int cfg_db(input int sel);
    return (sel == 2) ? 7 : 8;
  endfunction
  function automatic int cfg_pm(input int sel);
    return (sel == 0) ? 1 : ((sel == 1) ? 2 : 0);
  endfunction
  function automatic int cfg_sb(input int sel);
    return (sel == 1) ? 2 : 1;
  endfunction
  function automatic int frame_len(input int sel);
    return BC * (1 + cfg_db(sel) + ((cfg_pm(sel) != 0) ? 1 : 0) + cfg_sb(sel));
  endfunction

  // Level of bit slot 'slot' of a frame: start, data LSB first, optional parity, stop(s).
  function automatic logic [31:0] exp_bit(input int sel, input int data, input int slot);
    int db = cfg_db(sel);
    int p  = 0;
    if (slot == 0) return 32'd0;
    if (slot <= db) return 32'((data >> (slot - 1)) & 1);
    if (cfg_pm(sel) != 0 && slot == db + 1) begin
      for (int i = 0; i < db; i++) p = p ^ ((data >> i) & 1);
      if (cfg_pm(sel) == 2) p = 1 - p;
      return 32'(p);
    end
    return 32'd1;
  endfunction

  function automatic logic [31:0] get_tx(input int sel);
    return (sel == 0) ? 32'(tx_a) : ((sel == 1) ? 32'(tx_b) : 32'(tx_c));
  endfunction
  function automatic logic [31:0] get_done(input int sel);
    return (sel == 0) ? 32'(done_a) : ((sel == 1) ? 32'(done_b) : 32'(done_c));
  endfunction
  function automatic logic [31:0] get_busy(input int sel);
    return (sel == 0) ? 32'(busy_a) : ((sel == 1) ? 32'(busy_b) : 32'(busy_c));
  endfunction
  function automatic logic [31:0] get_cnt(input int sel);
    return (sel == 0) ? 32'(cnt_a) : ((sel == 1) ? 32'(cnt_b) : 32'(cnt_c));
  endfunction
  function automatic logic [31:0] get_st(input int sel);
    return (sel == 0) ? 32'(st_a) : ((sel == 1) ? 32'(st_b) : 32'(st_c));
  endfunction
  function automatic logic [31:0] get_rdy(input int sel);
    return (sel == 0) ? 32'(if_a.tx_ready) : ((sel == 1) ? 32'(if_b.tx_ready) : 32'(if_c.tx_ready));
  endfunction

  task automatic set_in(input int sel, input logic vld, input int d);
    case (sel)
      0: begin if_a.tx_valid = vld; if_a.tx_data = d[7:0]; end
      1: begin if_b.tx_valid = vld; if_b.tx_data = d[7:0]; end
      default: begin if_c.tx_valid = vld; if_c.tx_data = d[6:0]; end
    endcase
  endtask

  // One-cycle push, starting and ending on a falling edge; the FIFO must have room.
  task automatic push_one(input int sel, input int d);
    int m = d & ((1 << cfg_db(sel)) - 1);
    set_in(sel, 1'b1, m);
    chk($sformatf("s%0d push_ready", sel), get_rdy(sel), 32'd1);
    exp_q.push_back(m);
    @(negedge clk);
    set_in(sel, 1'b0, 0);
  endtask

  // Checks n frames clock by clock. 'fixed' means called on the falling edge right
  // after the push edge into an idle, empty DUT, so the start bit is due 2 clocks later.
  task automatic check_frames(input int sel, input int n, input bit fixed);
    int len = frame_len(sel);
    int w   = 0;
    int d;
    if (fixed) begin
      @(negedge clk);
      chk($sformatf("s%0d line_high_before_start", sel), get_tx(sel), 32'd1);
      @(negedge clk);
    end else begin
      while (get_tx(sel) !== 32'd0 && w < 4000) begin
        @(negedge clk);
        w++;
      end
      chk($sformatf("s%0d start_bit_timeout", sel), 32'(w < 4000), 32'd1);
    end
    for (int f = 0; f < n; f++) begin
      if (exp_q.size() == 0) begin
        chk($sformatf("s%0d expected_queue_empty", sel), 32'd0, 32'd1);
        return;
      end
      d = exp_q.pop_front();
      for (int c = 0; c < len; c++) begin
        chk($sformatf("s%0d f%0d c%0d tx", sel, f, c), get_tx(sel), exp_bit(sel, d, c / BC));
        chk($sformatf("s%0d f%0d c%0d tx_done", sel, f, c), get_done(sel), 32'(c == len - 1));
        if (c < len - 1) chk($sformatf("s%0d f%0d c%0d tx_busy", sel, f, c), get_busy(sel), 32'd1);
        @(negedge clk);
      end
    end
  endtask

  task automatic check_idle(input int sel);
    chk($sformatf("s%0d idle tx", sel), get_tx(sel), 32'd1);
    chk($sformatf("s%0d idle tx_busy", sel), get_busy(sel), 32'd0);
    chk($sformatf("s%0d idle tx_done", sel), get_done(sel), 32'd0);
    chk($sformatf("s%0d idle state", sel), get_st(sel), 32'd0);
    chk($sformatf("s%0d idle fifo_count", sel), get_cnt(sel), 32'd0);
    chk($sformatf("s%0d idle tx_ready", sel), get_rdy(sel), 32'd1);
  endtask

  // Random burst of n characters pushed on consecutive cycles into an idle DUT.
  task automatic burst(input int sel, input int n);
    fork
      begin
        for (int i = 0; i < n; i++) push_one(sel, int'($urandom_range(0, 511)));
      end
      begin
        @(negedge clk);
        check_frames(sel, n, 1'b1);
      end
    join
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(0, 1'b0, 0);
    set_in(1, 1'b0, 0);
    set_in(2, 1'b0, 0);

    // Reset state on all three instances.
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) check_idle(s);
    rst = 1'b1;
    @(negedge clk);

    // Even parity, 0xA5: 176-clock frame, 2-clock latency.
    push_one(0, 8'hA5);
    chk("t1 fifo_count_after_push", get_cnt(0), 32'd1);
    check_frames(0, 1, 1'b1);
    check_idle(0);

    // Odd parity, two stop bits, 0x07: 192-clock frame.
    push_one(1, 8'h07);
    check_frames(1, 1, 1'b1);
    check_idle(1);

    // 7 data bits, no parity, 0x41: 144-clock frame.
    push_one(2, 7'h41);
    check_frames(2, 1, 1'b1);
    check_idle(2);

    // Five pushes in five cycles, then hold a sixth while full; five contiguous frames.
    d4[0] = 8'h12; d4[1] = 8'hF0; d4[2] = 8'h81; d4[3] = 8'h7E; d4[4] = 8'h55;
    fork
      begin
        for (int i = 0; i < 5; i++) push_one(0, d4[i]);
        chk("t4 fifo_full_count", get_cnt(0), 32'd4);
        chk("t4 fifo_full_ready", get_rdy(0), 32'd0);
        set_in(0, 1'b1, 8'h3C);
        for (int i = 0; i < 20; i++) begin
          chk("t5 held_ready", get_rdy(0), 32'd0);
          chk("t5 held_count", get_cnt(0), 32'd4);
          @(negedge clk);
        end
        set_in(0, 1'b0, 0);
      end
      begin
        @(negedge clk);
        check_frames(0, 5, 1'b1);
      end
    join
    check_idle(0);

    // Reset during data bit 3 of the first of two queued frames.
    push_one(0, 8'hA5);
    push_one(0, 8'h5A);
    repeat (70) @(negedge clk);
    chk("t6 bit3_before_reset", get_tx(0), 32'd0);
    rst = 1'b0;
    #1;
    chk("t6 reset tx", get_tx(0), 32'd1);
    chk("t6 reset fifo_count", get_cnt(0), 32'd0);
    chk("t6 reset state", get_st(0), 32'd0);
    chk("t6 reset busy", get_busy(0), 32'd0);
    chk("t6 reset ready", get_rdy(0), 32'd1);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6 in_reset tx_done", get_done(0), 32'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6 after_reset tx_done", get_done(0), 32'd0);
      chk("t6 after_reset tx", get_tx(0), 32'd1);
      chk("t6 after_reset state", get_st(0), 32'd0);
    end
    push_one(0, 8'h3C);
    check_frames(0, 1, 1'b1);
    check_idle(0);

    // Random bursts on random instances.
    for (int r = 0; r < 8; r++) begin
      int sel = int'($urandom_range(0, 2));
      int n   = int'($urandom_range(1, 4));
      repeat (int'($urandom_range(0, 5))) @(negedge clk);
      burst(sel, n);
      check_idle(sel);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
